melody_sequencer: RTL

Autonomous tune player that sits directly upstream of `buzzer_control` and drives its `note_div` input in place of the push-button note select. On a play request it walks an internal 8-entry song ROM. For each entry it emits the note's divider value for the programmed number of beats, then inserts a short silent articulation gap before the next entry. It reports progress for the seven-segment display path and signals completion.

---
 rtl/melody_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// Autonomous 8-entry tune player feeding buzzer_control's note divider.
// Optional `MELODY_LOOP_EN: wrap from entry 7 back to entry 0 instead of finishing.
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 10_000_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic        stop,
    input  logic        pause,
    output logic [19:0] note_div,
    output logic [2:0]  note_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPlay = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [26:0] GapLoad = 27'(GAP_CYCLES - 32'd1);

`ifdef MELODY_LOOP_EN
    localparam bit LoopEn = 1'b1;
`else
    localparam bit LoopEn = 1'b0;
`endif

    // Song entries encoded as {note[2:0], dur[2:0]}, beats = dur + 1.
    function automatic logic [5:0] song_rom(input logic [2:0] idx);
        unique case (idx)
            3'd0:    return {3'd1, 3'd0};
            3'd1:    return {3'd2, 3'd0};
            3'd2:    return {3'd3, 3'd0};
            3'd3:    return {3'd1, 3'd0};
            3'd4:    return {3'd3, 3'd1};
            3'd5:    return {3'd2, 3'd0};
            3'd6:    return {3'd1, 3'd0};
            default: return {3'd0, 3'd0};
        endcase
    endfunction

    function automatic logic [2:0] rom_note(input logic [2:0] idx);
        logic [5:0] entry;
        entry = song_rom(idx);
        return entry[5:3];
    endfunction

    function automatic logic [2:0] rom_dur(input logic [2:0] idx);
        logic [5:0] entry;
        entry = song_rom(idx);
        return entry[2:0];
    endfunction

    function automatic logic [19:0] note_to_div(input logic [2:0] note);
        unique case (note)
            3'd1:    return 20'd76628;
            3'd2:    return 20'd68259;
            3'd3:    return 20'd60606;
            3'd4:    return 20'd57306;
            3'd5:    return 20'd51020;
            3'd6:    return 20'd45454;
            3'd7:    return 20'd40495;
            default: return 20'd0;
        endcase
    endfunction

    // Tone portion of a note; the counter runs from load value down to 0 inclusive.
    function automatic logic [26:0] tone_load(input logic [2:0] dur);
        logic [31:0] beats;
        beats = {29'd0, dur} + 32'd1;
        return 27'(beats * BEAT_CYCLES - GAP_CYCLES - 32'd1);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [19:0] note_div_q, note_div_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        paused;
    logic [2:0]  nxt_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        paused  = pause && ((state_q == StPlay) || (state_q == StGap));
        nxt_idx = idx_q + 3'd1;

        if (stop) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (play) begin
                        state_d = StPlay;
                        idx_d   = '0;
                        cnt_d   = tone_load(rom_dur(3'd0));
                    end
                end
                StPlay: begin
                    if (!paused) begin
                        if (cnt_q == '0) begin
                            state_d = StGap;
                            cnt_d   = GapLoad;
                        end else begin
                            cnt_d = cnt_q - 27'd1;
                        end
                    end
                end
                StGap: begin
                    if (!paused) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 27'd1;
                        end else if ((idx_q != 3'd7) || LoopEn) begin
                            state_d = StPlay;
                            idx_d   = nxt_idx;
                            cnt_d   = tone_load(rom_dur(nxt_idx));
                        end else begin
                            state_d = StDone;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d     = (state_d == StPlay) || (state_d == StGap);
        done_d     = (state_d == StDone);
        note_div_d = ((state_d == StPlay) && !paused) ? note_to_div(rom_note(idx_d)) : 20'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            note_div_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            note_div_q <= note_div_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign note_div = note_div_q;
    assign note_idx = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
